coeff_bus_master: RTL and testbench
===================================

Name: coeff_bus_master

Overview:
- Initiator side of the FIR coefficient/RAM control bus that the filter's FSM controller consumes.
- Accepts 40 coefficients over a valid/ready stream and performs a coefficient-update session: flag high, writes indexed 0..39, then release.
- Afterwards, on every 600 kHz sample strobe, issues one 10-address read sweep (CsnRam low, WrnRam high).
- Sits between the host/test harness and the filter top.

Parameters:
- NUM_COEFF, 40, total coefficients per update session.
- TAPS_PER_BANK, 10, addresses per RAM bank; read sweep length.
- DATA_W, 16, coefficient width (signed).
- ADDR_W, 4, RAM address width.
- IDX_W, 6, coefficient index width.

Ports:
- iClk_12M  in  1  system clock, 12 MHz.
- iRsn  in  1  reset; asynchronous, active-low.
- iUpdateReq  in  1  one-cycle pulse: start a coefficient update.
- iCoeffValid  in  1  coefficient stream valid.
- iCoeffData  in  DATA_W  signed coefficient; transferred when iCoeffValid && oCoeffReady.
- oCoeffReady  out  1  master can accept a coefficient.
- iEnSample_600k  in  1  sample strobe; starts a read sweep.
- oCoeffiUpdateFlag  out  1  update-session flag.
- oCsnRam  out  1  RAM chip select, active-low.
- oWrnRam  out  1  RAM write enable, active-low.
- oAddrRam  out  ADDR_W  bank-local address, 0..9.
- oWrDtRam  out  DATA_W  write data.
- oNumOfCoeff  out  IDX_W  global coefficient index, 0..39; selects the bank at the receiver.
- oBusy  out  1  high in any state other than IDLE and RUN.
- oUpdateDone  out  1  one-cycle pulse at end of update.
- oOverrun  out  1  sticky: sample strobe arrived during a sweep.

Behaviour:
- All outputs are registered.
- Reset (async, any state):
  - state goes to IDLE.
  - oCoeffiUpdateFlag=0, oCsnRam=1, oWrnRam=1.
  - oAddrRam, oWrDtRam, oNumOfCoeff = 0.
  - oCoeffReady, oBusy, oUpdateDone, oOverrun = 0.
  - Pending request and counters cleared.
- Idle bus value: flag=0, csn=1, wrn=1, addr/data/num=0.
- IDLE: idle bus. On iUpdateReq, go to LOAD.
- LOAD: idle bus, oCoeffReady=1. On handshake: capture beat0, k=0, addr=0, go to ARM.
- ARM (exactly 1 cycle): flag=1, csn=0, wrn=0, num=0, addr=0, data=beat0. Go to WRITE.
  - This cycle is the receiver's Idle-to-write entry cycle; beat0 is therefore presented again in WRITE.
- WRITE: flag=1, csn=0, wrn=0; presents beat k.
  - oCoeffReady=1 while k<NUM_COEFF-1.
  - On handshake: k+1, addr wraps 9->0 (at k=10, 20, 30), data captured; shown next cycle.
  - Without a handshake, the bus holds k/addr/data unchanged (idempotent rewrite).
  - Every beat is presented at least 1 cycle.
  - When k==NUM_COEFF-1 has been presented one cycle, go to END.
- END (1 cycle): flag=0, csn=1, wrn=1, addr/data/num=0; oUpdateDone=1. Go to RUN.
- RUN: idle bus.
  - iEnSample_600k: go to READ, a=0.
  - Otherwise, iUpdateReq or pending request set: go to LOAD, pending cleared.
  - Sample has priority; a simultaneous iUpdateReq sets pending.
- READ: flag=0, csn=0, wrn=1, addr=a, data=0, num=0.
  - a increments each cycle; after a==TAPS_PER_BANK-1, return to RUN (exactly 10 cycles).
  - iEnSample_600k during READ: ignored, oOverrun<=1 (sticky until reset).
  - iUpdateReq during READ: sets pending.
- iUpdateReq in LOAD/ARM/WRITE/END: ignored.
- iEnSample_600k outside RUN/READ: ignored, no overrun.
- oNumOfCoeff and oAddrRam are kept as separate counters; no divide.

Decomposition:
- Shared package `fir_bus_pkg`:
  - state enum: IDLE, LOAD, ARM, WRITE, END, RUN, READ.
  - constants NUM_COEFF=40, TAPS_PER_BANK=10.
  - the idle bus value.
- One sub-module, `coeff_index_counter`:
  - k (0..NUM_COEFF-1) plus bank-local addr with 9->0 wrap.
  - clear/increment inputs, last flag.
  - Reused for the read sweep.

Test Plan:
- Reset mid-WRITE at k=20: all outputs return to idle values asynchronously. The next update restarts at num=0, addr=0.
- Back-to-back stream 0x0001..0x0028: ARM shows data 0x0001. WRITE shows num 0..39 consecutively, with addr wrapping to 0 at num 10/20/30 and data=num+1. END follows, with oUpdateDone for 1 cycle, then RUN.
- Stall: valid low for 5 cycles after beat num=12 is accepted. num=12, addr=2, data=0x000D are held 5+ cycles, flags steady, no index skip.
- In RUN, pulse iEnSample_600k: the next 10 cycles show csn=0, wrn=1, addr 0..9, then csn=1. A second pulse on sweep cycle 4 leaves the sweep unchanged and sets oOverrun=1.
- iEnSample_600k and iUpdateReq in the same RUN cycle: the 10-cycle sweep runs first, then LOAD is entered the cycle after returning to RUN.
- iUpdateReq while in WRITE: ignored. Exactly one oUpdateDone pulse, 40 distinct indices.

Source files
------------

// File: rtl/fir_bus_pkg.sv
// Shared types and constants for the FIR coefficient/RAM control bus.
// Both the bus master and its index counter import this package.
package fir_bus_pkg;

    localparam int NUM_COEFF     = 40;
    localparam int TAPS_PER_BANK = 10;
    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 4;
    localparam int IDX_W         = 6;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_COEFF - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TAPS_PER_BANK - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WRITE,
        END,
        RUN,
        READ
    } state_e;

    typedef struct packed {
        logic              flag;
        logic              csn;
        logic              wrn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  num;
    } bus_t;

    // Bus value seen by the receiver whenever no session or sweep is active.
    localparam bus_t BUS_IDLE = '{flag: 1'b0, csn: 1'b1, wrn: 1'b1,
                                  addr: '0, data: '0, num: '0};

endpackage

// File: rtl/coeff_index_counter.sv
// Global coefficient index plus bank-local address that wraps at the bank size.
// Exposes next-state values so the owner can register its outputs in step.
module coeff_index_counter
    import fir_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              incr,
    output logic [IDX_W-1:0]  idx_next,
    output logic [ADDR_W-1:0] addr_next,
    output logic              idx_last,
    output logic              addr_last
);

    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (clear) begin
            idx_d  = '0;
            addr_d = '0;
        end else if (incr) begin
            idx_d  = idx_q + IDX_W'(1);
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            addr_q <= '0;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign idx_next  = idx_d;
    assign addr_next = addr_d;
    assign idx_last  = (idx_q == IDX_LAST);
    assign addr_last = (addr_q == ADDR_LAST);

endmodule

// File: rtl/coeff_bus_master.sv
// Initiator of the FIR coefficient/RAM bus: runs coefficient-update sessions
// from a valid/ready stream and a 10-address read sweep per sample strobe.
module coeff_bus_master
    import fir_bus_pkg::*;
(
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iUpdateReq,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    input  logic              iEnSample_600k,
    output logic              oCoeffiUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic [IDX_W-1:0]  oNumOfCoeff,
    output logic              oBusy,
    output logic              oUpdateDone,
    output logic              oOverrun
);

    state_e            state_q, state_d;
    bus_t              bus_q, bus_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] data_nxt;

    logic              cnt_clear, cnt_incr;
    logic [IDX_W-1:0]  idx_next;
    logic [ADDR_W-1:0] addr_next;
    logic              idx_last, addr_last;
    logic              hs;

    coeff_index_counter u_cnt (
        .clk       (iClk_12M),
        .rst_n     (iRsn),
        .clear     (cnt_clear),
        .incr      (cnt_incr),
        .idx_next  (idx_next),
        .addr_next (addr_next),
        .idx_last  (idx_last),
        .addr_last (addr_last)
    );

    assign hs = iCoeffValid && ready_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        data_nxt  = bus_q.data;

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (iUpdateReq) state_d = LOAD;
            end
            LOAD: begin
                cnt_clear = 1'b1;
                if (hs) begin
                    state_d  = ARM;
                    data_nxt = iCoeffData;
                end
            end
            ARM:  state_d = WRITE;
            WRITE: begin
                if (idx_last) begin
                    state_d = END;
                end else if (hs) begin
                    cnt_incr = 1'b1;
                    data_nxt = iCoeffData;
                end
            end
            END: begin
                cnt_clear = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                cnt_clear = 1'b1;
                // The sample strobe wins; a coincident update request waits in pending.
                if (iEnSample_600k) begin
                    state_d = READ;
                    if (iUpdateReq) pending_d = 1'b1;
                end else if (iUpdateReq || pending_q) begin
                    state_d   = LOAD;
                    pending_d = 1'b0;
                end
            end
            READ: begin
                if (addr_last) state_d = RUN;
                else           cnt_incr = 1'b1;
                if (iEnSample_600k) overrun_d = 1'b1;
                if (iUpdateReq)     pending_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the registered bus lines up with state_q.
        bus_d = BUS_IDLE;
        case (state_d)
            ARM, WRITE: begin
                bus_d.flag = 1'b1;
                bus_d.csn  = 1'b0;
                bus_d.wrn  = 1'b0;
                bus_d.addr = addr_next;
                bus_d.data = data_nxt;
                bus_d.num  = idx_next;
            end
            READ: begin
                bus_d.csn  = 1'b0;
                bus_d.addr = addr_next;
            end
            default: bus_d = BUS_IDLE;
        endcase

        ready_d = (state_d == LOAD) || ((state_d == WRITE) && (idx_next != IDX_LAST));
        busy_d  = !((state_d == IDLE) || (state_d == RUN));
        done_d  = (state_d == END);
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= IDLE;
            bus_q     <= BUS_IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            pending_q <= pending_d;
        end
    end

    assign oCoeffiUpdateFlag = bus_q.flag;
    assign oCsnRam           = bus_q.csn;
    assign oWrnRam           = bus_q.wrn;
    assign oAddrRam          = bus_q.addr;
    assign oWrDtRam          = bus_q.data;
    assign oNumOfCoeff       = bus_q.num;
    assign oCoeffReady       = ready_q;
    assign oBusy             = busy_q;
    assign oUpdateDone       = done_q;
    assign oOverrun          = overrun_q;

endmodule

// File: tb/tb_coeff_bus_master.sv
// Directed self-checking bench for coeff_bus_master: update sessions, stalls,
// read sweeps, overrun and request arbitration, with expectations computed here.
`timescale 1ns/1ps
module tb_coeff_bus_master;

    logic        clk = 1'b0;
    logic        iRsn;
    logic        iUpdateReq;
    logic        iCoeffValid;
    logic [15:0] iCoeffData;
    logic        oCoeffReady;
    logic        iEnSample_600k;
    logic        oCoeffiUpdateFlag;
    logic        oCsnRam;
    logic        oWrnRam;
    logic [3:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [5:0]  oNumOfCoeff;
    logic        oBusy;
    logic        oUpdateDone;
    logic        oOverrun;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_ovr      = 1'b0;

    // Bus packed as {flag, csn, wrn, addr[3:0], data[15:0], num[5:0]}.
    localparam logic [28:0] BUS_IDLE_V = {1'b0, 1'b1, 1'b1, 4'd0, 16'd0, 6'd0};
    wire [28:0] bus_obs = {oCoeffiUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oNumOfCoeff};
    // Status packed as {ready, busy, done, overrun}.
    wire [3:0]  st_obs  = {oCoeffReady, oBusy, oUpdateDone, oOverrun};

    coeff_bus_master dut (
        .iClk_12M          (clk),
        .iRsn              (iRsn),
        .iUpdateReq        (iUpdateReq),
        .iCoeffValid       (iCoeffValid),
        .iCoeffData        (iCoeffData),
        .oCoeffReady       (oCoeffReady),
        .iEnSample_600k    (iEnSample_600k),
        .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
        .oCsnRam           (oCsnRam),
        .oWrnRam           (oWrnRam),
        .oAddrRam          (oAddrRam),
        .oWrDtRam          (oWrDtRam),
        .oNumOfCoeff       (oNumOfCoeff),
        .oBusy             (oBusy),
        .oUpdateDone       (oUpdateDone),
        .oOverrun          (oOverrun)
    );

    always #42 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Full update session; stall_at/req_at/abort_at = -1 disables that feature.
    task automatic run_update(input logic [15:0] base, input int stall_at, input int req_at,
                              input int abort_at, input bit in_load);
        logic [28:0] exp_bus;
        logic [3:0]  exp_st;
        int          n;
        iUpdateReq = !in_load;
        @(negedge clk);
        iUpdateReq = 1'b0;
        exp_st = {1'b1, 1'b1, 1'b0, exp_ovr};
        tests_run++;
        if (bus_obs !== BUS_IDLE_V) begin
            tests_failed++; $display("FAIL load_bus got=%h exp=%h", bus_obs, BUS_IDLE_V);
        end
        tests_run++;
        if (st_obs !== exp_st) begin
            tests_failed++; $display("FAIL load_status got=%b exp=%b", st_obs, exp_st);
        end
        iCoeffValid = 1'b1;
        iCoeffData  = base;

        @(negedge clk);
        exp_bus = {3'b100, 4'd0, base, 6'd0};
        exp_st  = {1'b0, 1'b1, 1'b0, exp_ovr};
        tests_run++;
        if (bus_obs !== exp_bus) begin
            tests_failed++; $display("FAIL arm_bus got=%h exp=%h", bus_obs, exp_bus);
        end
        tests_run++;
        if (st_obs !== exp_st) begin
            tests_failed++; $display("FAIL arm_status got=%b exp=%b", st_obs, exp_st);
        end
        iEnSample_600k = 1'b1;
        iCoeffData     = base + 16'd1;

        for (int k = 0; k < 40; k++) begin
            n = (k == stall_at) ? 6 : 1;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                iEnSample_600k = 1'b0;
                exp_bus = {3'b100, 4'(k % 10), base + 16'(k), 6'(k)};
                exp_st  = {(k < 39), 1'b1, 1'b0, exp_ovr};
                tests_run++;
                if (bus_obs !== exp_bus) begin
                    tests_failed++;
                    $display("FAIL write_bus k=%0d c=%0d got=%h exp=%h", k, c, bus_obs, exp_bus);
                end
                tests_run++;
                if (st_obs !== exp_st) begin
                    tests_failed++;
                    $display("FAIL write_status k=%0d c=%0d got=%b exp=%b", k, c, st_obs, exp_st);
                end
                if (k == abort_at) return;
                iUpdateReq  = (k == req_at) && (c == 0);
                iCoeffValid = (c == n - 1);
                iCoeffData  = (c == n - 1) ? base + 16'(k + 1) : 16'hDEAD;
            end
        end

        @(negedge clk);
        iUpdateReq  = 1'b0;
        iCoeffValid = 1'b0;
        exp_st = {1'b0, 1'b1, 1'b1, exp_ovr};
        tests_run++;
        if (bus_obs !== BUS_IDLE_V) begin
            tests_failed++; $display("FAIL end_bus got=%h exp=%h", bus_obs, BUS_IDLE_V);
        end
        tests_run++;
        if (st_obs !== exp_st) begin
            tests_failed++; $display("FAIL end_status got=%b exp=%b", st_obs, exp_st);
        end

        exp_st = {1'b0, 1'b0, 1'b0, exp_ovr};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus_obs !== BUS_IDLE_V || st_obs !== exp_st) begin
                tests_failed++;
                $display("FAIL run_after_update i=%0d got=%h/%b exp=%h/%b",
                         i, bus_obs, st_obs, BUS_IDLE_V, exp_st);
            end
        end
    endtask

    task automatic test_reset();
        iRsn = 1'b1; iUpdateReq = 1'b0; iCoeffValid = 1'b0;
        iCoeffData = 16'h0; iEnSample_600k = 1'b0;
        #5 iRsn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus_obs !== BUS_IDLE_V) begin
            tests_failed++; $display("FAIL reset_bus got=%h exp=%h", bus_obs, BUS_IDLE_V);
        end
        tests_run++;
        if (st_obs !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_status got=%b exp=0000", st_obs);
        end
        iRsn = 1'b1;
        iEnSample_600k = 1'b1;
        @(negedge clk);
        iEnSample_600k = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus_obs !== BUS_IDLE_V || st_obs !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_sample_ignored i=%0d got=%h/%b exp=%h/0000",
                         i, bus_obs, st_obs, BUS_IDLE_V);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_update(16'h0001, -1, -1, -1, 1'b0);
    endtask

    task automatic test_read_sweep();
        logic [28:0] exp_bus;
        logic [3:0]  exp_st;
        iEnSample_600k = 1'b1;
        for (int a = 0; a < 10; a++) begin
            @(negedge clk);
            exp_bus = {3'b001, 4'(a), 16'd0, 6'd0};
            exp_st  = {1'b0, 1'b1, 1'b0, (a >= 4)};
            tests_run++;
            if (bus_obs !== exp_bus) begin
                tests_failed++; $display("FAIL sweep_bus a=%0d got=%h exp=%h", a, bus_obs, exp_bus);
            end
            tests_run++;
            if (st_obs !== exp_st) begin
                tests_failed++; $display("FAIL sweep_status a=%0d got=%b exp=%b", a, st_obs, exp_st);
            end
            iEnSample_600k = (a == 3);
        end
        exp_ovr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus_obs !== BUS_IDLE_V || st_obs !== 4'b0001) begin
                tests_failed++;
                $display("FAIL sweep_return i=%0d got=%h/%b exp=%h/0001",
                         i, bus_obs, st_obs, BUS_IDLE_V);
            end
        end
    endtask

    task automatic test_stall();
        run_update(16'h0001, 12, -1, -1, 1'b0);
    endtask

    task automatic test_req_during_write();
        run_update(16'h0040, -1, 20, -1, 1'b0);
    endtask

    task automatic test_sample_and_req();
        logic [28:0] exp_bus;
        logic [3:0]  exp_st;
        iEnSample_600k = 1'b1;
        iUpdateReq     = 1'b1;
        exp_st = {1'b0, 1'b1, 1'b0, exp_ovr};
        for (int a = 0; a < 10; a++) begin
            @(negedge clk);
            iEnSample_600k = 1'b0;
            iUpdateReq     = 1'b0;
            exp_bus = {3'b001, 4'(a), 16'd0, 6'd0};
            tests_run++;
            if (bus_obs !== exp_bus || st_obs !== exp_st) begin
                tests_failed++;
                $display("FAIL both_sweep a=%0d got=%h/%b exp=%h/%b", a, bus_obs, st_obs, exp_bus, exp_st);
            end
        end
        @(negedge clk);
        exp_st = {1'b0, 1'b0, 1'b0, exp_ovr};
        tests_run++;
        if (bus_obs !== BUS_IDLE_V || st_obs !== exp_st) begin
            tests_failed++;
            $display("FAIL both_run got=%h/%b exp=%h/%b", bus_obs, st_obs, BUS_IDLE_V, exp_st);
        end
        run_update(16'h1000, -1, -1, -1, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        run_update(16'h0100, -1, -1, 20, 1'b0);
        #10;
        iRsn = 1'b0;
        iCoeffValid = 1'b0;
        iUpdateReq  = 1'b0;
        exp_ovr     = 1'b0;
        #1;
        tests_run++;
        if (bus_obs !== BUS_IDLE_V) begin
            tests_failed++; $display("FAIL async_reset_bus got=%h exp=%h", bus_obs, BUS_IDLE_V);
        end
        tests_run++;
        if (st_obs !== 4'b0000) begin
            tests_failed++; $display("FAIL async_reset_status got=%b exp=0000", st_obs);
        end
        @(negedge clk);
        iRsn = 1'b1;
        run_update(16'h0200, -1, -1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_read_sweep();
        test_stall();
        test_req_during_write();
        test_sample_and_req();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
